discard_pile: RTL
=================

// Module: discard_pile
// PURPOSE
//  Holds the UNO discard pile: cards played by players are stacked and the top card is
//  exported for move legality checks. On a refill request, it streams every card except
//  the top back into Deck through Deck's in_use/insert/insert_card handshake. It sits
//  directly upstream of Deck's insert port. Cards are 6 bits: {color[1:0], value[3:0]}.
// PARAMETERS
//  DEPTH   108  max cards held (whole deck)
//  CARD_W  6    card width; must match Deck
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  synchronous, active-high reset
//  push         in   1                  play a card onto the pile (1-cycle strobe)
//  push_card    in   CARD_W             card being played
//  push_err     out  1                  1-cycle pulse: push dropped (pile full or busy)
//  top_card     out  CARD_W             current top of pile (0 when empty)
//  top_valid    out  1                  pile non-empty
//  count        out  $clog2(DEPTH+1)    cards in pile
//  recycle_req  in   1                  request to return pile (minus top card) to Deck
//  recycle_busy out  1                  recycle sequence in progress
//  recycle_done out  1                  1-cycle pulse: recycle finished
//  deck_done    in   1                  Deck's done output (1 = Deck idle)
//  in_use       out  1                  to Deck; 0 = Deck clears itself and accepts inserts
//  insert       out  1                  to Deck; 1-cycle insert strobe
//  insert_card  out  CARD_W             to Deck; card for insert
// BEHAVIOUR
//  Reset (sync, active-high; wins over all other inputs, including mid-recycle):
//    count=0, top_card=0, top_valid=0, in_use=1, insert=0, insert_card=0,
//    recycle_busy=0, recycle_done=0, push_err=0, state=S_IDLE.
//  Storage: stack mem[0..DEPTH-1]; mem[count-1] is top. All outputs are registered.
//  Push (accepted only in S_IDLE with count<DEPTH): mem[count]<=push_card, count+1;
//    top_card/top_valid update on the next cycle. Push while full or in any non-IDLE
//    state: state is unchanged and push_err pulses for 1 cycle.
//  FSM:
//   S_IDLE:    recycle_req && count>=2 -> S_RELEASE, idx<=0, recycle_busy<=1.
//              recycle_req && count<2  -> recycle_done pulse next cycle; Deck untouched.
//              push and recycle_req in the same cycle: push is accepted first, and the
//              recycle uses the updated count (the pushed card becomes the kept top).
//   S_RELEASE: in_use=0; wait for deck_done==0 (Deck has cleared) -> S_INSERT.
//   S_INSERT:  insert=1 and insert_card=mem[idx] for exactly 1 cycle; idx+1 -> S_GAP.
//   S_GAP:     insert=0 for 1 cycle (Deck needs 1 cycle in its insert state).
//              If idx==count-1 -> S_RETURN, otherwise -> S_INSERT.
//   S_RETURN:  in_use=1; wait for deck_done==1 -> S_IDLE, mem[0]<=mem[count-1],
//              count<=1, recycle_busy<=0, recycle_done pulses for 1 cycle.
//  Insert spacing is fixed at 1 strobe per 2 cycles. A recycle of N cards takes
//    2*(N-1) cycles plus the two Deck wait phases.
//  recycle_req while busy: ignored (no error flag).
//  Widths: idx and count share width $clog2(DEPTH+1); count never exceeds DEPTH and
//    never underflows, because no pop exists outside a recycle.
//  top_card is held during a recycle and equals the preserved card afterwards.
// STRUCTURE
//  Shared package uno_pkg holds: typedef card_t (logic [5:0]), color constants
//    RED/YELLOW/GREEN/BLUE=0..3, value constants SKIP=10, REVERSE=11, DRAW2=12,
//    WILD=13, WILD4=14, and DECK_SIZE=108. Deck and discard_pile both import it.
//  One sub-module: card_stack (DEPTH x CARD_W register stack with push, indexed read,
//    and a "collapse to top" operation). The FSM and handshake live in discard_pile.
// TESTING
//  1. Reset, push 6'h05, then 6'h1B -> count=2, top_card=6'h1B, top_valid=1 the cycle
//     after the second push.
//  2. Push 108 cards, then push one more -> push_err=1 for 1 cycle, count stays 108,
//     top unchanged.
//  3. Pile {05,1B,2C,3A}, recycle_req, Deck model -> in_use falls; after deck_done=0,
//     insert pulses at alternate cycles with 05,1B,2C; in_use rises; after deck_done=1,
//     recycle_done pulses, count=1, top_card=3A.
//  4. count=1, recycle_req -> recycle_done next cycle; in_use stays 1; insert never asserted.
//  5. Push 2C and recycle_req in the same cycle (pile {05}) -> exactly 1 insert (05);
//     final top_card=2C; push during S_INSERT -> push_err pulse, pile unchanged.
//  6. Assert reset after the 2nd insert of scenario 3 -> next cycle in_use=1, insert=0,
//     count=0, recycle_busy=0.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared UNO card definitions used by Deck and discard_pile.
// Also holds the discard pile state encoding.
package uno_pkg;

  localparam int DECK_SIZE = 108;
  localparam int CARD_BITS = 6;

  typedef logic [5:0] card_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  localparam logic [3:0] SKIP    = 4'd10;
  localparam logic [3:0] REVERSE = 4'd11;
  localparam logic [3:0] DRAW2   = 4'd12;
  localparam logic [3:0] WILD    = 4'd13;
  localparam logic [3:0] WILD4   = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_INSERT  = 3'd2,
    S_GAP     = 3'd3,
    S_RETURN  = 3'd4
  } dp_state_e;

  function automatic card_t make_card(input logic [1:0] color, input logic [3:0] value);
    return {color, value};
  endfunction

endpackage

// File: rtl/discard_pile_card_stack.sv
// Register stack of cards: indexed write, indexed read, and a collapse that
// moves the top entry down to slot 0.
module card_stack
  import uno_pkg::*;
#(
  parameter int DEPTH  = DECK_SIZE,
  parameter int CARD_W = CARD_BITS
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH+1)-1:0] wr_idx_i,
  input  logic [CARD_W-1:0]          wr_card_i,
  input  logic                       collapse_i,
  input  logic [$clog2(DEPTH+1)-1:0] top_idx_i,
  input  logic [$clog2(DEPTH+1)-1:0] rd_idx_i,
  output logic [CARD_W-1:0]          rd_card_o
);

  localparam int IW = $clog2(DEPTH+1);
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);

  logic [CARD_W-1:0] mem_q [DEPTH];
  logic [CARD_W-1:0] top_card_s;

  // Out-of-range indices read as an empty card rather than X.
  always_comb begin
    rd_card_o  = '0;
    top_card_s = '0;
    if (rd_idx_i < DEPTH_C) begin
      rd_card_o = mem_q[rd_idx_i];
    end else begin
      rd_card_o = '0;
    end
    if (top_idx_i < DEPTH_C) begin
      top_card_s = mem_q[top_idx_i];
    end else begin
      top_card_s = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (collapse_i) begin
      mem_q[0] <= top_card_s;
    end else if (wr_en_i && (wr_idx_i < DEPTH_C)) begin
      mem_q[wr_idx_i] <= wr_card_i;
    end
  end

endmodule

// File: rtl/discard_pile.sv
// UNO discard pile: stacks played cards, exports the top card, and on request
// streams all but the top card back into Deck over its insert handshake.
module discard_pile
  import uno_pkg::*;
#(
  parameter int DEPTH  = DECK_SIZE,
  parameter int CARD_W = CARD_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [CARD_W-1:0]          push_card,
  output logic                       push_err,
  output logic [CARD_W-1:0]          top_card,
  output logic                       top_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       recycle_req,
  output logic                       recycle_busy,
  output logic                       recycle_done,
  input  logic                       deck_done,
  output logic                       in_use,
  output logic                       insert,
  output logic [CARD_W-1:0]          insert_card
);

  localparam int IW = $clog2(DEPTH+1);
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
  localparam logic [IW-1:0] ONE_C   = IW'(1);
  localparam logic [IW-1:0] TWO_C   = IW'(2);

  dp_state_e         state_q, state_d;
  logic [IW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CARD_W-1:0] top_card_q, top_card_d;
  logic              top_valid_q, top_valid_d;
  logic              push_err_q, push_err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_use_q, in_use_d;
  logic              insert_q, insert_d;
  logic [CARD_W-1:0] insert_card_q, insert_card_d;
  logic              push_ok_s;
  logic              collapse_s;
  logic [CARD_W-1:0] rd_card_s;

  card_stack #(
    .DEPTH  (DEPTH),
    .CARD_W (CARD_W)
  ) u_stack (
    .clk        (clk),
    .wr_en_i    (push_ok_s),
    .wr_idx_i   (count_q),
    .wr_card_i  (push_card),
    .collapse_i (collapse_s),
    .top_idx_i  (count_q - ONE_C),
    .rd_idx_i   (idx_q),
    .rd_card_o  (rd_card_s)
  );

  // Push is resolved before the recycle decision so a same-cycle push is kept as top.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    top_card_d = top_card_q;
    done_d     = 1'b0;
    collapse_s = 1'b0;
    push_ok_s  = push && (state_q == S_IDLE) && (count_q < DEPTH_C);

    if (push_ok_s) begin
      count_d    = count_q + ONE_C;
      top_card_d = push_card;
    end else begin
      count_d    = count_q;
      top_card_d = top_card_q;
    end

    case (state_q)
      S_IDLE: begin
        if (recycle_req && (count_d >= TWO_C)) begin
          state_d = S_RELEASE;
          idx_d   = '0;
        end else if (recycle_req) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!deck_done) begin
          state_d = S_INSERT;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_INSERT: begin
        idx_d   = idx_q + ONE_C;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (idx_q == (count_q - ONE_C)) begin
          state_d = S_RETURN;
        end else begin
          state_d = S_INSERT;
        end
      end
      S_RETURN: begin
        if (deck_done) begin
          state_d    = S_IDLE;
          collapse_s = 1'b1;
          count_d    = ONE_C;
          done_d     = 1'b1;
        end else begin
          state_d = S_RETURN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with state_q.
    in_use_d      = !((state_d == S_RELEASE) || (state_d == S_INSERT) || (state_d == S_GAP));
    insert_d      = (state_d == S_INSERT);
    insert_card_d = (state_d == S_INSERT) ? rd_card_s : insert_card_q;
    busy_d        = (state_d != S_IDLE);
    push_err_d    = push && !push_ok_s;
    top_valid_d   = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      idx_q         <= '0;
      top_card_q    <= '0;
      top_valid_q   <= 1'b0;
      push_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      in_use_q      <= 1'b1;
      insert_q      <= 1'b0;
      insert_card_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      top_card_q    <= top_card_d;
      top_valid_q   <= top_valid_d;
      push_err_q    <= push_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      in_use_q      <= in_use_d;
      insert_q      <= insert_d;
      insert_card_q <= insert_card_d;
    end
  end

  assign push_err     = push_err_q;
  assign top_card     = top_card_q;
  assign top_valid    = top_valid_q;
  assign count        = count_q;
  assign recycle_busy = busy_q;
  assign recycle_done = done_q;
  assign in_use       = in_use_q;
  assign insert       = insert_q;
  assign insert_card  = insert_card_q;

endmodule
